// File: rtl/acc_seq.sv
// acc_seq: word-time sequencer and arbiter for the accumulator register.
// Grants one requester at a time, aligns the grant to the next drum word
// boundary, then drives the AR control strobes for a whole number of words.
module acc_seq #(
  parameter int WC_W = 7
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic            T1,
  input  logic            T29,
  input  logic            CMD_REQ,
  input  logic [1:0]      CMD_OP,
  input  logic [WC_W-1:0] CMD_WC,
  output logic            CMD_ACK,
  input  logic            KEY_REQ,
  output logic            KEY_ACK,
  output logic            TR,
  output logic            D7,
  output logic            DU,
  output logic            DV,
  output logic            CS,
  output logic            KEY_RETURN,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_TRA = 2'b01;
  localparam logic [1:0] OP_TVA = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [WC_W-1:0] CNT_ZERO = {WC_W{1'b0}};
  localparam logic [WC_W-1:0] CNT_ONE  = WC_W'(32'd1);

  // Strobe vector order: {TR, D7, DU, DV, CS, KEY_RETURN}.
  // DU and DV are mutually exclusive by construction of this table.
  function automatic logic [5:0] strobe_decode(input logic [1:0] op);
    logic [5:0] s;
    case (op)
      OP_ADD:  s = 6'b110100;
      OP_TRA:  s = 6'b111000;
      OP_TVA:  s = 6'b100010;
      OP_CLR:  s = 6'b000001;
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [WC_W-1:0] cnt_q, cnt_d;
  logic [5:0]      strb_q, strb_d;
  logic            cmd_ack_q, cmd_ack_d;
  logic            key_ack_q, key_ack_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Word boundaries are taken from T29 alone (T29 wins if both are high),
  // so T1 carries no information this block needs.
  logic unused_t1_s;
  assign unused_t1_s = T1;

  // Arbitration, word alignment and word counting.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    cmd_ack_d = 1'b0;
    key_ack_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (KEY_REQ) begin
          op_d      = OP_CLR;
          cnt_d     = CNT_ONE;
          key_ack_d = 1'b1;
          state_d   = ST_ARM;
        end else if (CMD_REQ) begin
          op_d      = CMD_OP;
          cnt_d     = (CMD_WC == CNT_ZERO) ? CNT_ONE : CMD_WC;
          cmd_ack_d = 1'b1;
          state_d   = ST_ARM;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (T29) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RUN: begin
        if (T29) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes and BUSY are decoded from the next state so the registered
  // copies line up exactly with the RUN window.
  always_comb begin
    strb_d = 6'b000000;
    if (state_d == ST_RUN) begin
      strb_d = strobe_decode(op_q);
    end else begin
      strb_d = 6'b000000;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_CLR;
      cnt_q     <= CNT_ZERO;
      strb_q    <= 6'b000000;
      cmd_ack_q <= 1'b0;
      key_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      strb_q    <= strb_d;
      cmd_ack_q <= cmd_ack_d;
      key_ack_q <= key_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TR         = strb_q[5];
  assign D7         = strb_q[4];
  assign DU         = strb_q[3];
  assign DV         = strb_q[2];
  assign CS         = strb_q[1];
  assign KEY_RETURN = strb_q[0];
  assign CMD_ACK    = cmd_ack_q;
  assign KEY_ACK    = key_ack_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq: a 29-bit word-time generator plus hand-computed
// ARM/RUN lengths and strobe patterns for each transaction.
module tb_acc_seq;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       T1, T29;
  logic       CMD_REQ, KEY_REQ;
  logic [1:0] CMD_OP;
  logic [6:0] CMD_WC;
  logic       CMD_ACK, KEY_ACK;
  logic       TR, D7, DU, DV, CS, KEY_RETURN, BUSY, DONE;
  logic [5:0] strb;

  int bitpos;
  int n_checks = 0;
  int n_errors = 0;

  assign strb = {TR, D7, DU, DV, CS, KEY_RETURN};

  acc_seq #(.WC_W(7)) dut (
    .CLOCK(CLOCK), .rst(rst), .T1(T1), .T29(T29),
    .CMD_REQ(CMD_REQ), .CMD_OP(CMD_OP), .CMD_WC(CMD_WC), .CMD_ACK(CMD_ACK),
    .KEY_REQ(KEY_REQ), .KEY_ACK(KEY_ACK),
    .TR(TR), .D7(D7), .DU(DU), .DV(DV), .CS(CS), .KEY_RETURN(KEY_RETURN),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLOCK = ~CLOCK;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge,
  // where the next bit time is also presented.
  task automatic tick();
    @(posedge CLOCK);
    #1;
    bitpos = (bitpos == 29) ? 1 : bitpos + 1;
    T1  = (bitpos == 1);
    T29 = (bitpos == 29);
  endtask

  task automatic wait_bit(input int n);
    for (int i = 0; i < 30 && bitpos != n; i++) tick();
  endtask

  // Called at the sample point of the clock in which the request is sampled.
  // Measures ACK, ARM length, RUN length/pattern and the DONE clock.
  task automatic run_txn(input string tag, input bit is_key, input bit drop,
                         input logic [5:0] exp_strb, input int exp_arm, input int exp_run);
    int arm_n, run_n, bad_n, guard;
    bad_n = 0;
    tick();
    check_eq({tag, " ack"}, is_key ? KEY_ACK : CMD_ACK, 32'd1);
    check_eq({tag, " busy"}, BUSY, 32'd1);
    if ((is_key ? CMD_ACK : KEY_ACK) !== 1'b0) bad_n++;
    if (strb !== 6'd0) bad_n++;
    if (drop) begin
      if (is_key) KEY_REQ = 1'b0;
      else CMD_REQ = 1'b0;
    end
    arm_n = 1;
    guard = 0;
    tick();
    while (strb === 6'd0 && guard < 40) begin
      if (BUSY !== 1'b1 || CMD_ACK !== 1'b0 || KEY_ACK !== 1'b0 || DONE !== 1'b0) bad_n++;
      arm_n++;
      guard++;
      tick();
    end
    check_eq({tag, " arm_len"}, arm_n, exp_arm);
    check_eq({tag, " run_starts_t1"}, bitpos, 32'd1);
    run_n = 0;
    guard = 0;
    while (BUSY === 1'b1 && guard < 5000) begin
      if (strb !== exp_strb || CMD_ACK !== 1'b0 || KEY_ACK !== 1'b0 || DONE !== 1'b0) bad_n++;
      run_n++;
      guard++;
      tick();
    end
    check_eq({tag, " run_len"}, run_n, exp_run);
    check_eq({tag, " done"}, DONE, 32'd1);
    check_eq({tag, " done_strb"}, strb, 32'd0);
    check_eq({tag, " done_t1"}, bitpos, 32'd1);
    check_eq({tag, " window_errs"}, bad_n, 32'd0);
  endtask

  initial begin
    int guard, stray;
    bitpos  = 1;
    T1      = 1'b1;
    T29     = 1'b0;
    rst     = 1'b1;
    CMD_REQ = 1'b0;
    KEY_REQ = 1'b0;
    CMD_OP  = 2'b00;
    CMD_WC  = 7'd0;
    tick();
    tick();
    check_eq("reset outputs", {strb, CMD_ACK, KEY_ACK, DONE}, 32'd0);
    check_eq("reset busy", BUSY, 32'd0);
    rst = 1'b0;
    tick();

    // Single ADD raised at bit 10: ARM is bits 11..29.
    wait_bit(10);
    CMD_REQ = 1'b1; CMD_OP = 2'b00; CMD_WC = 7'd1;
    run_txn("add1", 1'b0, 1'b1, 6'b110100, 19, 29);

    // KEY and CMD together: KEY wins, CMD follows after DONE.
    wait_bit(5);
    KEY_REQ = 1'b1; CMD_REQ = 1'b1; CMD_OP = 2'b01; CMD_WC = 7'd2;
    run_txn("key_first", 1'b1, 1'b1, 6'b000001, 24, 29);
    run_txn("tra2", 1'b0, 1'b1, 6'b111000, 28, 58);

    // Request sampled on the T29 clock: a full 29-clock ARM.
    wait_bit(29);
    CMD_REQ = 1'b1; CMD_OP = 2'b10; CMD_WC = 7'd1;
    run_txn("tva_t29", 1'b0, 1'b1, 6'b100010, 29, 29);

    // Zero count behaves as one word.
    wait_bit(20);
    CMD_REQ = 1'b1; CMD_OP = 2'b00; CMD_WC = 7'd0;
    run_txn("add_wc0", 1'b0, 1'b1, 6'b110100, 9, 29);

    // Maximum count, sampled on T28: 1-clock ARM, 127 words.
    wait_bit(28);
    CMD_REQ = 1'b1; CMD_OP = 2'b00; CMD_WC = 7'd127;
    run_txn("add_wc127", 1'b0, 1'b1, 6'b110100, 1, 3683);

    // Request held after ACK: second grant only after DONE.
    wait_bit(15);
    CMD_REQ = 1'b1; CMD_OP = 2'b10; CMD_WC = 7'd1;
    run_txn("b2b_first", 1'b0, 1'b0, 6'b100010, 14, 29);
    run_txn("b2b_second", 1'b0, 1'b1, 6'b100010, 28, 29);

    // Reset in word 2 of a 3-word ADD.
    wait_bit(3);
    CMD_REQ = 1'b1; CMD_OP = 2'b00; CMD_WC = 7'd3;
    tick();
    CMD_REQ = 1'b0;
    guard = 0;
    while (strb === 6'd0 && guard < 40) begin
      guard++;
      tick();
    end
    repeat (35) tick();
    check_eq("pre_reset strb", strb, 32'b110100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_reset strb", strb, 32'd0);
    check_eq("mid_reset busy", BUSY, 32'd0);
    check_eq("mid_reset done", DONE, 32'd0);
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({strb, BUSY, DONE, CMD_ACK, KEY_ACK} !== 10'd0) stray++;
    end
    check_eq("post_reset quiet", stray, 32'd0);

    // A fresh request after reset proves the sequencer is back in IDLE.
    wait_bit(12);
    KEY_REQ = 1'b1;
    run_txn("key_after_rst", 1'b1, 1'b1, 6'b000001, 17, 29);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acc_seq.md
# acc_seq

Word-time sequencer and arbiter for the accumulator register (AR) and its serial adder. It accepts operation requests from the command decoder and from the front-panel key logic and aligns each request to a drum word boundary. For a programmed number of word times it drives the AR control strobes (TR, D7, DU, DV, CS, KEY_RETURN). These strobes are never asserted outside a granted word window.

## Interface
- WC_W, default 7: width of the word-count field (up to 108 words per long line).
- CLOCK  in  1  bit-time clock.
- rst  in  1  synchronous reset, active-high.
- T1  in  1  high during bit time 1 (first bit of each 29-bit word).
- T29  in  1  high during bit time 29 (last bit of each word).
- CMD_REQ  in  1  command requester; level, held until CMD_ACK.
- CMD_OP  in  2  operation: 00 ADD (IB into AR+), 01 TRA (IB to AR), 10 TVA (IB via AR), 11 CLR.
- CMD_WC  in  WC_W  word times to run; 0 is treated as 1.
- CMD_ACK  out  1  one-clock grant pulse for CMD_REQ.
- KEY_REQ  in  1  front-panel return-key requester; level, held until KEY_ACK.
- KEY_ACK  out  1  one-clock grant pulse for KEY_REQ.
- TR, D7, DU, DV, CS, KEY_RETURN  out  1 each  AR control strobes.
- BUSY  out  1  high from grant through the last RUN clock.
- DONE  out  1  one-clock pulse after the final word.

## Operation
- States: IDLE, ARM, RUN.
- IDLE
  - KEY_REQ has priority over CMD_REQ.
  - On a sampled request, latch the operation and count, then go to ARM.
  - KEY grant: operation CLR, count 1.
  - CMD grant: CMD_OP and max(CMD_WC, 1).
  - The matching ACK is high in the first ARM clock only.
- ARM
  - Wait for T29. At the clock edge where T29=1, go to RUN.
  - RUN therefore begins exactly on the next T1 bit.
- RUN
  - Strobes are active every clock.
  - The word counter decrements at each T29.
  - At T29 with counter == 1, go to IDLE and pulse DONE.
- Strobe decode in RUN (all other strobes 0):
  - ADD: TR, D7, DV.
  - TRA: TR, D7, DU.
  - TVA: TR, CS.
  - CLR: KEY_RETURN.
- DU and DV are never both high.
- All strobes are 0 outside RUN.
- Requests arriving in ARM or RUN are not acknowledged. They stay pending and are arbitrated in the next IDLE clock.
- Strobes, ACKs, DONE and BUSY are registered; none is a combinational function of the inputs.
- A requester must drop its request in the clock following its ACK. A request still high in the IDLE clock after DONE is treated as a new request.

## Timing
- Reset values: state IDLE, counter 0, latched operation CLR.
- Every output resets to 0: TR, D7, DU, DV, CS, KEY_RETURN, CMD_ACK, KEY_ACK, BUSY, DONE.
- Reset mid-RUN: all strobes are 0 in the clock after rst; no DONE is issued; the pending operation is discarded.
- Grant latency: a request sampled at edge k gives ACK=1 and BUSY=1 in clock k+1.
- ARM length is 1 to 29 clocks.
  - A request sampled on a T29 clock enters ARM at T1 and waits a full word: 29 ARM clocks.
  - A request sampled on T28 gives a 1-clock ARM.
- RUN length is exactly 29·N clocks, T1 through T29 of N consecutive words.
- DONE is high in the T1 clock after the last word, with BUSY=0. IDLE may accept a new request in that same clock.
- T1 and T29 high together is illegal; the block acts on T29 only.
- The counter never wraps: a count of 0 loads as 1, and the maximum value 2^WC_W−1 runs fully.

## Test plan
- Reset mid-RUN: assert rst in word 2 of a 3-word ADD -> all strobes, BUSY and DONE are 0 the next clock; the state returns to IDLE; no DONE pulse.
- Single ADD: CMD_REQ, CMD_OP=00, CMD_WC=1, raised at bit time 10 -> CMD_ACK one clock; TR=D7=DV=1 for exactly 29 clocks from the next T1; DONE one clock after; DU=CS=0 throughout.
- Simultaneous requests: KEY_REQ and CMD_REQ (TRA, WC=2) both high in IDLE -> KEY_ACK first and a 1-word KEY_RETURN window. CMD_ACK follows in the DONE clock, then TR=D7=DU=1 for 58 clocks from the next T1 after the following T29.
- Alignment edge: CMD request (TVA, WC=1) sampled on the T29 clock -> 29 ARM clocks, then TR=CS=1 for 29 clocks.
- Zero count: CMD_WC=0 with ADD -> exactly one word of strobes. CMD_WC=127 -> 3683 RUN clocks with no wrap.
- Back-to-back: CMD_REQ held high after its ACK -> the second grant occurs only in the DONE/IDLE clock; no overlap of strobe windows.
